// File: rtl/dsp_pipe_ctrl.sv
// dsp_pipe_ctrl: control side of a chain of pipeline register stages.
// It produces the per-stage clock enables (CE) and stage resets (RST_STG),
// keeps one valid bit per stage and wraps the chain in a valid/ready handshake.
// Bubbles collapse because an empty stage always advances. A flush request
// discards every in-flight sample and holds the stage resets for FLUSH_LEN cycles.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | pipe empty, waiting for the first accepted sample
//   S_RUN   | at least one stage holds a valid sample
//   S_FLUSH | stage resets held asserted, handshake closed, FLUSH_LEN cycles
module dsp_pipe_ctrl #(
  parameter int STAGES    = 4,
  parameter int FLUSH_LEN = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic [STAGES-1:0] CE,
  output logic [STAGES-1:0] RST_STG,
  output logic [3:0]        occupancy,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [STAGES-1:0] v, v_nxt, adv;
  logic [3:0]        fcnt, fcnt_nxt;
  logic [3:0]        occ_nxt;

  function automatic logic [3:0] popcnt(input logic [STAGES-1:0] x);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < STAGES; i++) n = n + 4'(x[i]);
    return n;
  endfunction

  // Advance chain: a stage may move when it is empty or everything downstream moves.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = ~v[STAGES-1] | out_ready;
    adv[STAGES-1] = carry;
    for (int i = STAGES - 2; i >= 0; i--) begin
      carry  = ~v[i] | carry;
      adv[i] = carry;
    end
  end

  // Next-state, valid-bit update and output decode; reset forces outputs safe.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    v_nxt     = v;
    CE        = '0;
    RST_STG   = '1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != S_IDLE);

    case (state)
      S_IDLE, S_RUN: begin
        CE        = adv;
        in_ready  = adv[0];
        out_valid = v[STAGES-1];
        RST_STG   = '0;
        if (flush) begin
          // Flush takes priority over any transfer in this cycle.
          v_nxt     = '0;
          state_nxt = S_FLUSH;
          fcnt_nxt  = 4'(FLUSH_LEN - 1);
        end else begin
          if (adv[0]) v_nxt[0] = in_valid;
          for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) v_nxt[i] = v[i-1];
          end
          if (state == S_IDLE && in_valid && adv[0]) state_nxt = S_RUN;
          if (state == S_RUN && popcnt(v_nxt) == 4'd0) state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        v_nxt = '0;
        if (fcnt == 4'd0) state_nxt = S_IDLE;
        else              fcnt_nxt  = fcnt - 4'd1;
      end
      default: begin
        v_nxt     = '0;
        state_nxt = S_IDLE;
      end
    endcase

    if (rst) begin
      in_ready  = 1'b0;
      CE        = '0;
      RST_STG   = '1;
      out_valid = 1'b0;
      busy      = 1'b0;
    end
  end

  assign occ_nxt = popcnt(v_nxt);

  // State, valid bits, flush down-counter and registered occupancy.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= S_IDLE;
      v         <= '0;
      fcnt      <= 4'd0;
      occupancy <= 4'd0;
    end else begin
      state     <= state_nxt;
      v         <= v_nxt;
      fcnt      <= fcnt_nxt;
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// Self-checking bench for dsp_pipe_ctrl (STAGES=4, FLUSH_LEN=2): directed
// scenarios followed by random traffic, compared against a slot-level model.
module tb_dsp_pipe_ctrl;
  localparam int STAGES    = 4;
  localparam int FLUSH_LEN = 2;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic              CLK = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic              in_ready, out_valid, busy;
  logic [STAGES-1:0] CE, RST_STG;
  logic [3:0]        occupancy;

  int n_vec = 0;
  int n_err = 0;

  // Model: which slots hold a sample, the mode, and flush cycles remaining.
  bit mv[STAGES];
  int mstate = M_IDLE;
  int mcnt   = 0;

  always #5 CLK = ~CLK;

  dsp_pipe_ctrl #(.STAGES(STAGES), .FLUSH_LEN(FLUSH_LEN)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .CE        (CE),
    .RST_STG   (RST_STG),
    .occupancy (occupancy),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_occ();
    int n;
    n = 0;
    for (int i = 0; i < STAGES; i++) n += int'(mv[i]);
    return n;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input bit r, input bit iv, input bit orr, input bit fl);
    bit          moving[STAGES];
    bit          nv[STAGES];
    bit          all_full, e_ir, e_ov, e_busy, accept;
    logic [31:0] e_ce, e_rst;

    rst = r; in_valid = iv; out_ready = orr; flush = fl;
    @(negedge CLK);

    // A slot is stuck only if it and every slot after it are full and the sink stalls.
    all_full = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      all_full  = all_full & mv[i];
      moving[i] = !(all_full && !orr);
    end

    e_ce = 0; e_rst = 0; e_ir = 0; e_ov = 0; e_busy = 0;
    if (r) begin
      e_rst = (1 << STAGES) - 1;
    end else if (mstate == M_FLUSH) begin
      e_rst  = (1 << STAGES) - 1;
      e_busy = 1;
    end else begin
      for (int i = 0; i < STAGES; i++) if (moving[i]) e_ce |= (1 << i);
      e_ir   = moving[0];
      e_ov   = mv[STAGES-1];
      e_busy = (mstate != M_IDLE);
    end

    chk("in_ready",  32'(in_ready),  32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("CE",        32'(CE),        e_ce);
    chk("RST_STG",   32'(RST_STG),   e_rst);
    chk("busy",      32'(busy),      32'(e_busy));
    chk("occupancy", 32'(occupancy), 32'(model_occ()));

    @(posedge CLK);
    if (r) begin
      for (int i = 0; i < STAGES; i++) mv[i] = 0;
      mstate = M_IDLE;
      mcnt   = 0;
    end else if (mstate == M_FLUSH) begin
      mcnt--;
      if (mcnt == 0) mstate = M_IDLE;
    end else if (fl) begin
      for (int i = 0; i < STAGES; i++) mv[i] = 0;
      mstate = M_FLUSH;
      mcnt   = FLUSH_LEN;
    end else begin
      accept = iv && moving[0];
      nv[0] = moving[0] ? iv : mv[0];
      for (int i = 1; i < STAGES; i++) nv[i] = moving[i] ? mv[i-1] : mv[i];
      for (int i = 0; i < STAGES; i++) mv[i] = nv[i];
      if (mstate == M_IDLE && accept) mstate = M_RUN;
      else if (mstate == M_RUN && model_occ() == 0) mstate = M_IDLE;
    end
    #1;
  endtask

  initial begin
    // Reset for two cycles, then release with the pipe empty.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("release_CE", 32'(CE), 32'hF);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Single sample through an unstalled pipe.
    step(0, 1, 1, 0);
    repeat (6) step(0, 0, 1, 0);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Fill against a stalled sink, then stream one-in/one-out.
    repeat (6) step(0, 1, 0, 0);
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    repeat (5) step(0, 1, 1, 0);
    chk("stream_occ", 32'(occupancy), 32'd4);
    repeat (6) step(0, 0, 1, 0);

    // Bubble collapse: build v=1001, then one more sample with the sink stalled.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("bubble_occ", 32'(occupancy), 32'd3);
    chk("bubble_out_valid", 32'(out_valid), 32'd1);
    repeat (6) step(0, 0, 1, 0);

    // Flush with three samples in flight; second pulse inside FLUSH is ignored.
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("flush_done_busy", 32'(busy), 32'd0);
    chk("flush_done_occ", 32'(occupancy), 32'd0);

    // Reset mid-run with two samples in flight.
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("mid_run_occ", 32'(occupancy), 32'd2);
    step(1, 0, 0, 0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    repeat (6) step(0, 0, 1, 0);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 400; k++) begin
      step(bit'($urandom_range(0, 99) < 2),
           bit'($urandom_range(0, 99) < 70),
           bit'($urandom_range(0, 99) < 60),
           bit'($urandom_range(0, 99) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
